// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: state encoding, song entry
// field layout helpers and the end-marker value.
package song_pkg;

  // Sequencer state encoding (3 bits).
  typedef logic [2:0] song_state_t;

  localparam song_state_t ST_PAUSED  = 3'd0;
  localparam song_state_t ST_FETCH   = 3'd1;
  localparam song_state_t ST_DECODE  = 3'd2;
  localparam song_state_t ST_WAIT    = 3'd3;
  localparam song_state_t ST_ADVANCE = 3'd4;
  localparam song_state_t ST_DONE    = 3'd5;

  // An all-zero ROM word terminates the song.
  localparam int END_MARKER = 0;

  // Entry layout, MSB to LSB: {is_wait, voice, note, dur}.
  function automatic int note_lsb(input int dur_w);
    return dur_w;
  endfunction

  function automatic int voice_lsb(input int note_w, input int dur_w);
    return note_w + dur_w;
  endfunction

  function automatic int wait_bit(input int voice_w, input int note_w, input int dur_w);
    return voice_w + note_w + dur_w;
  endfunction

  function automatic int entry_width(input int voice_w, input int note_w, input int dur_w);
    return 1 + voice_w + note_w + dur_w;
  endfunction

endpackage

// File: rtl/song_wait_counter.sv
// Beat counter for rests: held at zero while clear is high, counts enabled
// beats otherwise, and flags the beat that brings the count up to target.
module song_wait_counter #(
  parameter int DUR_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             beat_en,
  input  logic [DUR_W-1:0] target,
  output logic [DUR_W-1:0] count,
  output logic             done
);

  logic [DUR_W-1:0] count_inc;

  assign count_inc = count + DUR_W'(1);
  // done is combinational so the owner can leave its wait state on this edge
  assign done      = beat_en && (count_inc == target);

  // Beat count; never passes target because the owner stops enabling it there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (beat_en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/multi_voice_song_reader.sv
// Multi-voice song sequencer. Walks one song of an external synchronous ROM,
// issues one-hot note pulses to up to NUM_VOICES players and times rests in
// beats. Optional feature macro SONG_LOOP_EN adds a `loop` input that restarts
// the song from entry 0 instead of stopping at the end.
//
// ROM handshake: there is no valid/ready pair. The ROM is a fixed-latency
// slave: rom_addr is held stable from FETCH through DECODE, and rom_data is
// taken as valid in DECODE, exactly one cycle after the address is presented.
module multi_voice_song_reader
  import song_pkg::*;
#(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_DEPTH = 64,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int NUM_VOICES = 3,
  localparam int SONG_W    = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
  localparam int IDX_W     = (SONG_DEPTH > 1) ? $clog2(SONG_DEPTH) : 1,
  localparam int VOICE_W   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
  localparam int ENTRY_W   = entry_width(VOICE_W, NOTE_W, DUR_W)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    play,
  input  logic [SONG_W-1:0]       song,
  input  logic                    beat,
`ifdef SONG_LOOP_EN
  input  logic                    loop,
`endif
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]      rom_data,
  output logic [NOTE_W-1:0]       note,
  output logic [DUR_W-1:0]        duration,
  output logic [NUM_VOICES-1:0]   new_note,
  output logic                    waiting,
  output logic                    song_done,
  output song_state_t             dbg_state
);

  localparam int NOTE_LSB  = note_lsb(DUR_W);
  localparam int VOICE_LSB = voice_lsb(NOTE_W, DUR_W);
  localparam int WAIT_BIT  = wait_bit(VOICE_W, NOTE_W, DUR_W);

  song_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic [SONG_W-1:0] song_q;
  logic [DUR_W-1:0]  wait_target;
  logic [DUR_W-1:0]  wait_count;
  logic              wait_done;

  // Entry fields, meaningful only in DECODE
  logic                  ent_wait;
  logic [VOICE_W-1:0]    ent_voice;
  logic [NOTE_W-1:0]     ent_note;
  logic [DUR_W-1:0]      ent_dur;
  logic                  ent_end;
  logic                  ent_sound;
  logic [NUM_VOICES-1:0] voice_hot;
  logic                  voice_ok;
  logic                  at_last;
  logic                  loop_sel;

  assign ent_wait  = rom_data[WAIT_BIT];
  assign ent_voice = rom_data[VOICE_LSB +: VOICE_W];
  assign ent_note  = rom_data[NOTE_LSB +: NOTE_W];
  assign ent_dur   = rom_data[DUR_W-1:0];
  assign ent_end   = (rom_data == ENTRY_W'(END_MARKER));
  assign ent_sound = (ent_note != '0) || (ent_dur != '0);
  assign at_last   = (idx == IDX_W'(SONG_DEPTH - 1));

`ifdef SONG_LOOP_EN
  assign loop_sel = loop;
`else
  assign loop_sel = 1'b0;
`endif

  assign rom_addr  = {song_q, idx};
  assign waiting   = (state == ST_WAIT);
  assign dbg_state = state;

  // One-hot target voice; out-of-range voices decode to all zeros
  always_comb begin
    voice_hot = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_hot[v] = (int'(ent_voice) == v);
    end
  end

  assign voice_ok = |voice_hot;

  // Beats only count inside WAIT while playing; leaving WAIT discards the count
  song_wait_counter #(
    .DUR_W (DUR_W)
  ) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state != ST_WAIT),
    .beat_en (beat && play && (state == ST_WAIT)),
    .target  (wait_target),
    .count   (wait_count),
    .done    (wait_done)
  );

  // Sequencer FSM with its index, song latch and registered note outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_PAUSED;
      idx         <= '0;
      song_q      <= '0;
      note        <= '0;
      duration    <= '0;
      new_note    <= '0;
      song_done   <= 1'b0;
      wait_target <= '0;
    end else begin
      new_note  <= '0;
      song_done <= 1'b0;
      case (state)
        ST_PAUSED: begin
          if (play) begin
            song_q <= song;
            if (song != song_q) idx <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= play ? ST_DECODE : ST_PAUSED;
        end
        ST_DECODE: begin
          if (!play) begin
            // nothing issued yet, so the entry is simply refetched on resume
            state <= ST_PAUSED;
          end else if (ent_end) begin
            idx       <= '0;
            song_done <= 1'b1;
            state     <= loop_sel ? ST_FETCH : ST_DONE;
          end else if (ent_wait) begin
            wait_target <= ent_dur;
            state       <= (ent_dur == '0) ? ST_ADVANCE : ST_WAIT;
          end else begin
            if (voice_ok && ent_sound) begin
              note     <= ent_note;
              duration <= ent_dur;
              new_note <= voice_hot;
            end
            state <= ST_ADVANCE;
          end
        end
        ST_WAIT: begin
          if (!play) state <= ST_PAUSED;
          else if (wait_done) state <= ST_ADVANCE;
        end
        ST_ADVANCE: begin
          // the step always completes so an issued note is never replayed
          if (at_last) begin
            idx       <= '0;
            song_done <= 1'b1;
            state     <= (loop_sel && play) ? ST_FETCH : ST_DONE;
          end else begin
            idx   <= idx + IDX_W'(1);
            state <= play ? ST_FETCH : ST_PAUSED;
          end
        end
        ST_DONE: begin
          if (!play) state <= ST_PAUSED;
        end
        default: begin
          state <= ST_PAUSED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_voice_song_reader.sv
// Directed bench for multi_voice_song_reader with a 4-song, 4-entry ROM.
module tb_multi_voice_song_reader;
  import song_pkg::*;

  localparam int NUM_SONGS  = 4;
  localparam int SONG_DEPTH = 4;
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int NUM_VOICES = 3;
  localparam int SONG_W     = 2;
  localparam int IDX_W      = 2;
  localparam int VOICE_W    = 2;
  localparam int ENTRY_W    = 1 + VOICE_W + NOTE_W + DUR_W;

  logic                    clk;
  logic                    reset_n;
  logic                    play;
  logic [SONG_W-1:0]       song;
  logic                    beat;
  logic [SONG_W+IDX_W-1:0] rom_addr;
  logic [ENTRY_W-1:0]      rom_data;
  logic [NOTE_W-1:0]       note;
  logic [DUR_W-1:0]        duration;
  logic [NUM_VOICES-1:0]   new_note;
  logic                    waiting;
  logic                    song_done;
  song_state_t             dbg_state;
`ifdef SONG_LOOP_EN
  logic                    loop;
`endif

  logic [ENTRY_W-1:0] rom [NUM_SONGS*SONG_DEPTH];

  int n_checks;
  int n_fails;

  multi_voice_song_reader #(
    .NUM_SONGS  (NUM_SONGS),
    .SONG_DEPTH (SONG_DEPTH),
    .NOTE_W     (NOTE_W),
    .DUR_W      (DUR_W),
    .NUM_VOICES (NUM_VOICES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .play      (play),
    .song      (song),
    .beat      (beat),
`ifdef SONG_LOOP_EN
    .loop      (loop),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .waiting   (waiting),
    .song_done (song_done),
    .dbg_state (dbg_state)
  );

  // Clock and synchronous ROM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [ENTRY_W-1:0] mk(input logic w, input int v, input int n, input int d);
    return {w, VOICE_W'(v), NOTE_W'(n), DUR_W'(d)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat_pulse();
    beat = 1'b1;
    step();
    beat = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    for (int i = 0; i < NUM_SONGS*SONG_DEPTH; i++) rom[i] = '0;
    // song 0: four notes, the second aimed at a non-existent voice, no end marker
    rom[0]  = mk(1'b0, 0, 1, 1);
    rom[1]  = mk(1'b0, 3, 2, 2);
    rom[2]  = mk(1'b0, 1, 3, 3);
    rom[3]  = mk(1'b0, 2, 4, 4);
    // song 1: single note then end
    rom[4]  = mk(1'b0, 2, 17, 8);
    // song 2: chord on voices 0,1,2 then a 4-beat rest
    rom[8]  = mk(1'b0, 0, 5, 1);
    rom[9]  = mk(1'b0, 1, 6, 2);
    rom[10] = mk(1'b0, 2, 7, 3);
    rom[11] = mk(1'b1, 0, 0, 4);
    // song 3: 5-beat rest, one note, end
    rom[12] = mk(1'b1, 0, 0, 5);
    rom[13] = mk(1'b0, 0, 9, 9);

    reset_n = 1'b0;
    play    = 1'b0;
    song    = '0;
    beat    = 1'b0;
`ifdef SONG_LOOP_EN
    loop    = 1'b0;
`endif
    steps(2);
    check("rst_state", dbg_state, ST_PAUSED);
    check("rst_addr", rom_addr, 0);
    check("rst_outs", {note, duration, new_note, waiting, song_done}, 0);
    #2 reset_n = 1'b1;
    step();

    // single note on voice 2, then end marker
    song = 2'd1;
    play = 1'b1;
    step();
    check("t1_fetch", dbg_state, ST_FETCH);
    check("t1_addr", rom_addr, 4'b0100);
    steps(2);
    check("t1_pulse", new_note, 3'b100);
    check("t1_note", note, 17);
    check("t1_dur", duration, 8);
    step();
    check("t1_pulse_end", new_note, 3'b000);
    steps(2);
    check("t1_done", song_done, 1'b1);
    check("t1_done_state", dbg_state, ST_DONE);
    check("t1_idx_clr", rom_addr, 4'b0100);
    step();
    check("t1_done_1cyc", song_done, 1'b0);
    play = 1'b0;
    step();
    check("t1_paused", dbg_state, ST_PAUSED);

    // chord of three notes then a 4-beat rest, wrapping at depth 4
    song = 2'd2;
    play = 1'b1;
    steps(3);
    check("t2_v0", {new_note, note}, {3'b001, 6'd5});
    steps(3);
    check("t2_v1", {new_note, note}, {3'b010, 6'd6});
    steps(3);
    check("t2_v2", {new_note, note, duration}, {3'b100, 6'd7, 6'd3});
    steps(3);
    check("t2_wait", waiting, 1'b1);
    beat_pulse();
    beat_pulse();
    beat_pulse();
    check("t2_wait_b3", waiting, 1'b1);
    beat = 1'b1;
    step();
    beat = 1'b0;
    check("t2_wait_exit", waiting, 1'b0);
    check("t2_adv", dbg_state, ST_ADVANCE);
    step();
    check("t2_wrap_done", song_done, 1'b1);
    play = 1'b0;
    step();

    // pause in the middle of a 5-beat rest
    song = 2'd3;
    play = 1'b1;
    steps(3);
    check("t3_wait", waiting, 1'b1);
    beat_pulse();
    beat_pulse();
    play = 1'b0;
    beat = 1'b1;
    step();
    beat = 1'b0;
    check("t3_paused", dbg_state, ST_PAUSED);
    check("t3_wait_low", waiting, 1'b0);
    play = 1'b1;
    step();
    check("t3_refetch", rom_addr, 4'b1100);
    steps(2);
    check("t3_rewait", waiting, 1'b1);
    beat_pulse();
    beat_pulse();
    beat_pulse();
    beat_pulse();
    check("t3_still_wait", dbg_state, ST_WAIT);
    beat = 1'b1;
    step();
    beat = 1'b0;
    check("t3_adv", dbg_state, ST_ADVANCE);
    steps(3);
    check("t3_note", {new_note, note, duration}, {3'b001, 6'd9, 6'd9});
    steps(3);
    check("t3_done", song_done, 1'b1);
    play = 1'b0;
    step();

    // four entries, no end marker: wrap back to index 0
    song = 2'd0;
    play = 1'b1;
    steps(3);
    check("t4_n0", {new_note, note}, {3'b001, 6'd1});
    steps(3);
    check("t4_drop", {new_note, note}, {3'b000, 6'd1});
    steps(3);
    check("t4_n2", {new_note, note}, {3'b010, 6'd3});
    steps(3);
    check("t4_n3", {new_note, note, duration}, {3'b100, 6'd4, 6'd4});
    check("t4_last_addr", rom_addr, 4'b0011);
    step();
    check("t4_done", {song_done, dbg_state}, {1'b1, ST_DONE});
    check("t4_addr0", rom_addr, 4'b0000);
    play = 1'b0;
    step();
    check("t4_paused_addr", {dbg_state, rom_addr}, {ST_PAUSED, 4'b0000});

    // asynchronous reset asserted mid-WAIT, off the clock edge
    song = 2'd3;
    play = 1'b1;
    steps(3);
    check("t5_wait", waiting, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_state", dbg_state, ST_PAUSED);
    check("t5_rst_outs", {rom_addr, note, duration, new_note, waiting, song_done}, 0);
    play = 1'b0;
    #3 reset_n = 1'b1;
    step();
    check("t5_after", dbg_state, ST_PAUSED);

`ifdef SONG_LOOP_EN
    // loop enabled: end marker restarts at entry 0 without a play toggle
    loop = 1'b1;
    song = 2'd1;
    play = 1'b1;
    steps(3);
    check("t6_first", new_note, 3'b100);
    steps(3);
    check("t6_done", {song_done, dbg_state}, {1'b1, ST_FETCH});
    check("t6_addr", rom_addr, 4'b0100);
    steps(2);
    check("t6_again", {new_note, note}, {3'b100, 6'd17});
    play = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/multi_voice_song_reader.md
# multi_voice_song_reader

Parametrised next-generation song sequencer for the music player. Walks a song stored in an external synchronous ROM, issues note events to up to NUM_VOICES note players so chords are possible, and times rests with an internal beat-counted wait. It sits between the song ROM and the per-voice note players, replacing the single-voice reader that waited on note_done.

## Interface
Parameters:
- NUM_SONGS, 4: songs in ROM. SONG_W = $clog2(NUM_SONGS).
- SONG_DEPTH, 64: entries per song, power of two. IDX_W = $clog2(SONG_DEPTH).
- NOTE_W, 6: note field width.
- DUR_W, 6: duration / wait-beats field width.
- NUM_VOICES, 3: voice outputs. VOICE_W = max(1, $clog2(NUM_VOICES)).

Ports:
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- play  in  1  run when high, pause when low.
- song  in  SONG_W  song select; sampled only on leaving PAUSED.
- beat  in  1  one-cycle beat strobe.
- rom_addr  out  SONG_W+IDX_W  {latched song, entry index}.
- rom_data  in  ENTRY_W  ROM word, valid the cycle after rom_addr; ENTRY_W = 1+VOICE_W+NOTE_W+DUR_W.
- note  out  NOTE_W  registered note of the last issued event.
- duration  out  DUR_W  registered duration of the last issued event.
- new_note  out  NUM_VOICES  one-hot, one-cycle pulse for the target voice.
- waiting  out  1  high while in WAIT.
- song_done  out  1  one-cycle pulse at end of song.

## Operation
- Entry layout MSB to LSB: {is_wait, voice, note, dur}.
- is_wait=1: rest for dur beats; voice and note ignored.
- is_wait=0 and note/dur non-zero: note event to voice. voice >= NUM_VOICES is dropped silently but still advances.
- Entry all-zero: end marker.
- States: PAUSED, FETCH, DECODE, WAIT, ADVANCE, DONE.
- PAUSED: play=1 -> FETCH. Song is latched on this exit; if it differs from the previous latched song, index clears to 0.
- FETCH: rom_addr presented -> DECODE.
- DECODE: rom_data is valid.
  - Note entry: load note/duration, pulse new_note[voice] -> ADVANCE.
  - Wait entry, dur=0 -> ADVANCE.
  - Wait entry, dur>0: clear beat counter -> WAIT.
  - End marker -> DONE.
- WAIT: count beats. When count reaches dur (count==dur after the increment) -> ADVANCE.
- ADVANCE: index+1. If index was SONG_DEPTH-1 -> DONE (wrap), else -> FETCH.
- DONE: song_done pulses on entry; index clears to 0; stay until play=0, then -> PAUSED.
- play=0 in any state except DONE -> PAUSED next cycle. Index is retained and the wait count is discarded; on resume the current entry is refetched and a wait restarts from 0.
- A note event issued in DECODE is never reissued on resume, because index has already advanced past it.

## Timing
- Reset values: state PAUSED, index 0, latched song 0, note 0, duration 0, new_note 0, waiting 0, song_done 0, beat count 0.
- Per-entry latency: note entry takes 3 cycles (FETCH, DECODE, ADVANCE). A chord of k notes issues pulses 3 cycles apart.
- Wait of N beats: WAIT exits in the cycle after the N-th beat strobe that falls inside WAIT.
- Beat strobes arriving in any other state are ignored.
- beat and play=0 in the same WAIT cycle: pause wins and the beat is ignored.
- Beat counter is DUR_W bits wide and cannot overflow, since it stops at dur.
- Changing song outside PAUSED has no effect until the next pause.

## Configuration
- SONG_LOOP_EN defined: adds input port `loop` (1 bit). At end of song with loop=1, song_done still pulses, index clears to 0, and the FSM goes to FETCH instead of DONE.
- SONG_LOOP_EN undefined: no loop port; end of song always goes to DONE.

## Structure
- Shared package song_pkg holds:
  - state encoding typedef (3 bits)
  - field-offset functions/constants for the entry layout
  - end-marker constant
- Sub-module song_wait_counter (DUR_W counter: clear, beat enable, target compare, done output) is instantiated once.
- The ROM is external; this block contains no memory.

## Test plan
- Single note: song 1, entry 0 = {0, voice 2, note 17, dur 8}, entry 1 = end -> new_note=3'b100 with note=17, duration=8 on the 3rd cycle after play rises; song_done 3 cycles later.
- Chord plus rest: three notes on voices 0,1,2, then wait dur=4 -> three pulses 3 cycles apart; waiting high until the cycle after the 4th beat.
- Pause mid-wait: wait dur=5, drop play after 2 beats, raise play again -> entry refetched; 5 fresh beats required before advance.
- Wrap: SONG_DEPTH=4, no end marker, four note entries -> fourth note issued, song_done pulses, index returns to 0 and rom_addr low bits = 0 after DONE/PAUSED.
- Loop (SONG_LOOP_EN, loop=1): end marker -> song_done pulse, then FETCH at index 0 with no play toggle; first note reissued.
- Async reset asserted mid-WAIT, deasserted off-edge -> all outputs zero immediately; FSM in PAUSED.
